// File: rtl/fetch_request_if.sv
// Fetch-request bundle: downstream hold/redirect controls, the instruction-memory
// request/response channel and the {pc, instr} presentation to the fetch latch.
// The master side is the fetch request unit; the slave side is its environment.
interface fetch_request_if;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        readValid;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  modport master (
    input  hold, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, readValid, pc_out, instr_out
  );

  modport slave (
    output hold, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, readValid, pc_out, instr_out
  );
endinterface

// File: rtl/fetch_request_unit.sv
// Fetch request unit: owns the PC, issues in-order instruction-memory reads under a
// credit limit, buffers responses with their PCs and presents the head entry to the
// fetch latch. Redirect flushes the buffer and squashes every outstanding read.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_squashed / perf_stall.
module fetch_request_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fetch_request_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed,
  output logic [31:0]     perf_stall
`endif
);

  // Counters must hold 0..BUF_DEPTH inclusive; pointers index BUF_DEPTH slots.
  localparam int            CW       = $clog2(BUF_DEPTH + 1);
  localparam int            IW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]   CREDITS  = (CW + 1)'(BUF_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);

  logic [31:0]   pc;
  logic [CW-1:0] occ;        // valid entries in the response buffer
  logic [CW-1:0] inflight;   // granted reads not yet returned (incl. squashed ones)
  logic [CW-1:0] discard;    // returning reads still to be dropped after a redirect
  logic [IW-1:0] buf_head;
  logic [IW-1:0] buf_tail;
  logic [IW-1:0] pf_head;
  logic [IW-1:0] pf_tail;

  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   pf_mem    [BUF_DEPTH];   // PCs of live (non-squashed) in-flight reads

  logic          rd_valid;
  logic          pop;
  logic          issue;
  logic          fire;
  logic          rsp;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          push;
  logic [CW:0]   credit_used;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + IW'(1);
  endfunction

  // Handshake decode: credits, issue, response routing and head consumption.
  always_comb begin
    rd_valid    = ~rst & (occ != '0);
    pop         = rd_valid & ~bus.hold;
    // A slot popped this cycle is already free for the next read, which keeps a
    // one-cycle memory streaming at one instruction per cycle with two entries.
    credit_used = {1'b0, inflight} + {1'b0, occ} - {{CW{1'b0}}, pop};
    issue       = ~rst & ~bus.redirect & (credit_used < CREDITS);
    fire        = issue & bus.imem_gnt;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    rsp         = ~rst & bus.imem_rvalid & (inflight != '0);
    rsp_drop    = rsp & (discard != '0);
    rsp_keep    = rsp & (discard == '0);
    push        = rsp_keep & ~bus.redirect;
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.readValid = rd_valid;
  assign bus.pc_out    = rd_valid ? buf_pc[buf_head]    : '0;
  assign bus.instr_out = rd_valid ? buf_instr[buf_head] : '0;

  // Control state: PC, credit counters and FIFO pointers; redirect outranks hold and issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      occ      <= '0;
      inflight <= '0;
      discard  <= '0;
      buf_head <= '0;
      buf_tail <= '0;
      pf_head  <= '0;
      pf_tail  <= '0;
    end else begin
      inflight <= inflight + CW'(fire) - CW'(rsp);
      if (bus.redirect) begin
        pc       <= bus.redirect_pc;
        occ      <= '0;
        buf_head <= '0;
        buf_tail <= '0;
        pf_head  <= '0;
        pf_tail  <= '0;
        // Every read still outstanding after this cycle belongs to the old stream.
        discard  <= inflight - CW'(rsp);
      end else begin
        if (fire) begin
          pc      <= pc + 32'd4;
          pf_tail <= ptr_inc(pf_tail);
        end
        if (rsp_drop) discard  <= discard - CW'(1);
        if (rsp_keep) pf_head  <= ptr_inc(pf_head);
        if (push)     buf_tail <= ptr_inc(buf_tail);
        if (pop)      buf_head <= ptr_inc(buf_head);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // Datapath storage: issued PCs and returned {pc, instr} pairs, no reset needed.
  always_ff @(posedge clk) begin
    if (fire) pf_mem[pf_tail] <= pc;
    if (push) begin
      buf_pc[buf_tail]    <= pf_mem[pf_head];
      buf_instr[buf_tail] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: consumed entries, squashed reads/entries, stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
      perf_stall    <= '0;
    end else begin
      if (pop)             perf_fetched <= perf_fetched + 32'd1;
      if (rd_valid & bus.hold) perf_stall <= perf_stall + 32'd1;
      // On redirect: entries left in the buffer after this cycle's pop, plus any
      // response landing this cycle, are all thrown away.
      if (bus.redirect)    perf_squashed <= perf_squashed + 32'(occ) - 32'(pop) + 32'(rsp);
      else if (rsp_drop)   perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule
